fp16_norm_round: RTL and testbench
==================================

# fp16_norm_round

Sequential normalize-and-round stage sitting directly downstream of the half-precision add/sub datapath. It accepts the raw aligned sum from the adder: sign, biased exponent, and an unnormalized significand with a carry bit and guard/round/sticky bits. It shifts the sum into normal or subnormal form one bit per cycle, rounds round-to-nearest-even, and emits a packed IEEE-754 binary16 result with status flags over a valid/ready handshake.

## Interface
- Parameters: none. All widths are fixed by the binary16 format.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream presents a raw sum.
- in_ready  out  1  block can accept; high only in IDLE and low while rst is high.
- in_sign  in  1  sign of the raw sum.
- in_exp  in  5  biased exponent of the larger operand, 1..30. Subnormal operands arrive with exponent 1.
- in_mant  in  15  [14] carry (2^1), [13] hidden (2^0), [12:3] fraction, [2] guard, [1] round, [0] sticky.
- in_nan, in_inf  in  1 each  special-case flags from the adder; in_nan has priority over in_inf.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- result  out  16  packed binary16 value.
- overflow, underflow, inexact  out  1 each  status flags for the current result.

## Operation
- States: IDLE, NORM, ROUND, DONE. Internal exponent is 6 bits.
- **IDLE**
  - On in_valid && in_ready, capture all inputs.
  - in_nan: result = 16'h7E00, go to DONE.
  - in_inf: result = {in_sign, 5'h1F, 10'h0}, go to DONE.
  - in_mant == 0: result = {in_sign, 15'h0}, go to DONE.
  - Otherwise go to NORM.
- **NORM** performs one action per cycle, in priority order:
  - If bit14 is set: shift right 1, OR the shifted-out bit into sticky, exp += 1, go to ROUND.
  - Else if bit13 is set, or exp == 1: go to ROUND with no shift.
  - Else: shift left 1 (zero fill), exp -= 1, stay in NORM. At most 13 left shifts.
- **ROUND**
  - G = bit2, R = bit1, S = bit0, lsb = bit3.
  - Increment the significand [14:3] when G && (R || S || lsb).
  - If the increment sets bit14: shift right 1, exp += 1.
  - If exp >= 31: result = {sign, 5'h1F, 10'h0}, overflow = 1.
  - Else if bit13 == 0: subnormal, encoded exponent 0.
  - Else: normal, result = {sign, exp[4:0], frac[12:3]}.
  - inexact = G | R | S, or overflow.
  - underflow = encoded exponent 0 && inexact.
  - Go to DONE.
- **DONE**
  - out_valid = 1; result and flags are held stable.
  - On out_ready, go to IDLE.
- No operand is accepted while busy; in_ready stays low outside IDLE.

## Timing
- Reset values: out_valid 0, result 16'h0000, all flags 0, state IDLE. in_ready is 0 while rst is high and 1 on the first cycle after release.
- Accept edge E0. out_valid goes high after edge E0+2+k, where k is the number of left shifts (0..13); the right-shift case has k = 0.
- Special and zero inputs: out_valid goes high after E0+1.
- out_valid falls on the edge where out_valid && out_ready.
- in_ready returns high the cycle after that handshake, so minimum issue interval is 4+k cycles.
- Reset mid-operation, in any state: the operation is discarded and the block returns to IDLE on the next edge with the reset values above.
- A simultaneous rst and handshake: rst wins.
- Holding out_ready low is unbounded; outputs must not change while held.

## Structure
- Shared package fp16_pkg:
  - Constants: EXP_W = 5, FRAC_W = 10, RAW_W = 15, EXP_BIAS = 15, EXP_INF = 5'h1F, QNAN = 16'h7E00.
  - State enum: IDLE / NORM / ROUND / DONE.
  - Raw-sum bit-index constants.
- Sub-module fp16_rne_round: combinational. Takes the significand [14:0] and 6-bit exp; returns rounded frac, adjusted exp, overflow, and inexact. Instantiated once, used in ROUND.

## Test plan
- **Carry:** in_exp=15, in_mant=15'h4000 (1.0+1.0) -> result 16'h4000, all flags 0, out_valid after E0+2.
- **Cancellation:** in_exp=15, in_mant=15'h0008 -> 10 left shifts, result 16'h1400, out_valid after E0+12.
- **Ties-to-even:**
  - in_exp=15, in_mant=15'h200C -> 16'h3C02, inexact=1.
  - in_mant=15'h2004 -> 16'h3C00, inexact=1.
- **Overflow:**
  - in_exp=30, in_mant=15'h4000 -> 16'h7C00, overflow=1.
  - in_exp=30, in_mant=15'h3FFC -> round carry gives 16'h7C00, overflow=1, inexact=1.
- **Subnormal and specials:**
  - in_exp=1, in_mant=15'h1000 -> 16'h0200, underflow=0.
  - in_exp=1, in_mant=15'h1004 -> 16'h0200, underflow=1, inexact=1.
  - in_mant=0, sign 1 -> 16'h8000 after E0+1.
  - in_nan=1 -> 16'h7E00.
- **Handshake and reset:**
  - Hold out_ready=0 for 5 cycles: result stable, in_ready=0 throughout.
  - Pulse rst during NORM: out_valid stays 0, in_ready=1 one cycle after release, next operand processes correctly.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared binary16 constants, raw-sum bit positions and the normalize/round state encoding.
package fp16_pkg;
  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int RAW_W    = 15;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 2 * EXP_BIAS + 1;

  localparam logic [EXP_W-1:0] EXP_INF = 5'h1F;
  localparam logic [15:0]      QNAN    = 16'h7E00;

  // Raw-sum layout: carry, hidden, fraction lsb, guard, round, sticky
  localparam int B_CARRY  = 14;
  localparam int B_HIDDEN = 13;
  localparam int B_LSB    = 3;
  localparam int B_G      = 2;
  localparam int B_R      = 1;
  localparam int B_S      = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/fp16_rne_round.sv
// Round-to-nearest-even of a normalized (or exp==1 subnormal) raw significand into a packed magnitude.
module fp16_rne_round
  import fp16_pkg::*;
(
  input  logic [RAW_W-1:0] sig,
  input  logic [5:0]       exp_in,
  output logic [14:0]      mag,
  output logic             overflow,
  output logic             underflow,
  output logic             inexact
);

  logic        g, r, s, inc, normal;
  logic [11:0] sum;
  logic [FRAC_W-1:0] frac;
  logic [5:0]  exp_out;

  always_comb begin
    g       = sig[B_G];
    r       = sig[B_R];
    s       = sig[B_S];
    inc     = g & (r | s | sig[B_LSB]);
    sum     = sig[B_CARRY:B_LSB] + {11'd0, inc};
    frac    = sum[9:0];
    normal  = sum[10];
    exp_out = exp_in;
    // Rounding carried into bit 14: the significand is exactly 2.0, renormalize
    if (sum[11]) begin
      frac    = sum[10:1];
      normal  = 1'b1;
      exp_out = exp_in + 6'd1;
    end
    overflow = (exp_out >= 6'(EXP_MAX));
    inexact  = g | r | s | overflow;
    mag      = {5'h00, frac};
    if (overflow) begin
      mag = {EXP_INF, 10'h000};
    end else if (normal) begin
      mag = {exp_out[4:0], frac};
    end
    underflow = !normal && inexact && !overflow;
  end

endmodule

// File: rtl/fp16_norm_round.sv
// Sequential normalize-and-round stage: one shift per cycle, RNE rounding, binary16 result over valid/ready.
//   state | meaning
//   IDLE  | waiting for a raw sum; specials resolved at capture
//   NORM  | one-bit right or left normalization per cycle
//   ROUND | apply RNE and pack result/flags (specials pass through)
//   DONE  | result valid, held until out_ready
module fp16_norm_round
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [RAW_W-1:0]  in_mant,
  input  logic              in_nan,
  input  logic              in_inf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       result,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);

  state_t state_q, state_d;
  logic             sign_q, sign_d;
  logic             spec_q, spec_d;
  logic [5:0]       exp_q, exp_d;
  logic [RAW_W-1:0] mant_q, mant_d;
  logic [15:0]      res_d;
  logic             ov_d, un_d, ix_d;

  logic [14:0] rnd_mag;
  logic        rnd_ov, rnd_un, rnd_ix;

  fp16_rne_round u_round (
    .sig       (mant_q),
    .exp_in    (exp_q),
    .mag       (rnd_mag),
    .overflow  (rnd_ov),
    .underflow (rnd_un),
    .inexact   (rnd_ix)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    spec_d  = spec_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    res_d   = result;
    ov_d    = overflow;
    un_d    = underflow;
    ix_d    = inexact;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = {1'b0, in_exp};
          mant_d  = in_mant;
          spec_d  = 1'b1;
          state_d = ROUND;
          // Specials are packed now; ROUND only clears the flags for them
          if (in_nan) begin
            res_d = QNAN;
          end else if (in_inf) begin
            res_d = {in_sign, EXP_INF, 10'h000};
          end else if (in_mant == '0) begin
            res_d = {in_sign, 15'h0000};
          end else begin
            spec_d  = 1'b0;
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mant_q[B_CARRY]) begin
          mant_d  = {1'b0, mant_q[14:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + 6'd1;
          state_d = ROUND;
        end else if (mant_q[B_HIDDEN] || exp_q <= 6'd1) begin
          state_d = ROUND;
        end else begin
          mant_d = {mant_q[13:0], 1'b0};
          exp_d  = exp_q - 6'd1;
        end
      end
      ROUND: begin
        state_d = DONE;
        if (spec_q) begin
          ov_d = 1'b0;
          un_d = 1'b0;
          ix_d = 1'b0;
        end else begin
          res_d = {sign_q, rnd_mag};
          ov_d  = rnd_ov;
          un_d  = rnd_un;
          ix_d  = rnd_ix;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      spec_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      result    <= 16'h0000;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      spec_q    <= spec_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      result    <= res_d;
      overflow  <= ov_d;
      underflow <= un_d;
      inexact   <= ix_d;
    end
  end

endmodule

// File: tb/tb_fp16_norm_round.sv
// Randomized bench for fp16_norm_round against an exact-arithmetic RNE model with a latency check.
module tb_fp16_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_nan, in_inf;
  logic [4:0]  in_exp;
  logic [14:0] in_mant;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        overflow, underflow, inexact;

  fp16_norm_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_nan    (in_nan),
    .in_inf    (in_inf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        ov, un, ix;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Exact value is m * 2^(e-28); quantize to the binary16 grid at the target exponent.
  function automatic exp_t model(input logic s, input logic [4:0] e, input logic [14:0] m,
                                 input logic nan, input logic inf);
    exp_t   x;
    int     p, ei, ee, sh, d;
    longint n, rem, half, mag;
    logic   ix;
    x.res = 16'h0; x.ov = 1'b0; x.un = 1'b0; x.ix = 1'b0; x.lat = 1;
    if (nan) x.res = 16'h7E00;
    else if (inf) x.res = {s, 15'h7C00};
    else if (m == 15'h0) x.res = {s, 15'h0000};
    else begin
      p = 0;
      for (int i = 0; i < 15; i++) if (m[i]) p = i;
      ei = int'(e) + p - 13;
      ee = (ei < 1) ? 1 : ei;
      sh = int'(e) - 3 - ee;
      if (sh >= 0) begin
        n  = longint'(m) << sh;
        ix = 1'b0;
      end else begin
        d    = -sh;
        n    = longint'(m) >> d;
        rem  = longint'(m) - (n << d);
        half = longint'(1) << (d - 1);
        if (rem > half || (rem == half && n[0])) n = n + 1;
        ix = (rem != 0);
      end
      mag = longint'(ee - 1) * 1024 + n;
      if (mag >= 31 * 1024) begin
        x.res = {s, 15'h7C00}; x.ov = 1'b1; x.ix = 1'b1;
      end else begin
        x.res = {s, mag[14:0]}; x.ix = ix; x.un = (mag < 1024) && ix;
      end
      x.lat = (p >= 13) ? 2 : 2 + (((13 - p) < (int'(e) - 1)) ? (13 - p) : (int'(e) - 1));
    end
    return x;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: sample pre-edge handshakes, then check post-edge outputs.
  logic hs, acc, rs;
  int   lat = 0;
  bit   pend = 1'b0;
  exp_t cur;
  always begin
    @(posedge clk);
    hs  = out_valid && out_ready && !rst;
    acc = in_valid && in_ready && !rst;
    rs  = rst;
    #1;
    if (rs) begin
      sbq.delete();
      pend = 1'b0;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_result", {16'h0, result}, 32'h0);
      chk("rst_flags", {29'h0, overflow, underflow, inexact}, 32'h0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    end else begin
      if (hs) begin
        if (sbq.size() != 0) void'(sbq.pop_front());
        done_cnt++;
      end
      if (acc) begin
        pend = 1'b1;
        lat  = 0;
      end else if (pend) lat++;
      if (out_valid) begin
        if (sbq.size() == 0) chk("unexpected_valid", {31'h0, out_valid}, 32'h0);
        else begin
          cur = sbq[0];
          chk("result", {16'h0, result}, {16'h0, cur.res});
          chk("flags", {29'h0, overflow, underflow, inexact}, {29'h0, cur.ov, cur.un, cur.ix});
          chk("in_ready_busy", {31'h0, in_ready}, 32'h0);
          if (pend) begin
            chk("latency", lat, cur.lat);
            pend = 1'b0;
          end
        end
      end else if (pend && lat > 40) begin
        chk("valid_timeout", lat, 32'd40);
        pend = 1'b0;
      end
    end
  end

  task automatic issue(input logic s, input logic [4:0] e, input logic [14:0] m,
                       input logic nan, input logic inf);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("issue_ready_timeout", {31'h0, in_ready}, 32'h1);
      return;
    end
    in_sign = s; in_exp = e; in_mant = m; in_nan = nan; in_inf = inf;
    in_valid = 1'b1;
    sbq.push_back(model(s, e, m, nan, inf));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == start) chk("done_timeout", done_cnt - start, 32'd1);
  endtask

  task automatic directed(input string name, input logic s, input logic [4:0] e,
                          input logic [14:0] m, input logic nan, input logic inf,
                          input logic [15:0] res, input logic [2:0] flg, input int l);
    exp_t x;
    x = model(s, e, m, nan, inf);
    chk({name, "_model_res"}, {16'h0, x.res}, {16'h0, res});
    chk({name, "_model_flags"}, {29'h0, x.ov, x.un, x.ix}, {29'h0, flg});
    chk({name, "_model_lat"}, x.lat, l);
    issue(s, e, m, nan, inf);
    wait_done();
  endtask

  logic [15:0] held;
  int          r, p, nw;
  logic [4:0]  re;
  logic [14:0] rm;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 5'd0;
    in_mant = 15'h0; in_nan = 1'b0; in_inf = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_ready_during_rst", {31'h0, in_ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {31'h0, in_ready}, 32'h1);
    chk("out_valid_after_rst", {31'h0, out_valid}, 32'h0);

    directed("carry",     0, 5'd15, 15'h4000, 0, 0, 16'h4000, 3'b000, 2);
    directed("cancel",    0, 5'd15, 15'h0008, 0, 0, 16'h1400, 3'b000, 12);
    directed("tie_odd",   0, 5'd15, 15'h200C, 0, 0, 16'h3C02, 3'b001, 2);
    directed("tie_even",  0, 5'd15, 15'h2004, 0, 0, 16'h3C00, 3'b001, 2);
    directed("ovf_carry", 0, 5'd30, 15'h4000, 0, 0, 16'h7C00, 3'b101, 2);
    directed("ovf_round", 0, 5'd30, 15'h3FFC, 0, 0, 16'h7C00, 3'b101, 2);
    directed("sub_exact", 0, 5'd1,  15'h1000, 0, 0, 16'h0200, 3'b000, 2);
    directed("sub_inex",  0, 5'd1,  15'h1004, 0, 0, 16'h0200, 3'b011, 2);
    directed("neg_zero",  1, 5'd9,  15'h0000, 0, 0, 16'h8000, 3'b000, 1);
    directed("nan",       1, 5'd9,  15'h1234, 1, 1, 16'h7E00, 3'b000, 1);
    directed("neg_inf",   1, 5'd7,  15'h2000, 0, 1, 16'hFC00, 3'b000, 1);
    directed("sub_to_norm", 0, 5'd1, 15'h1FFC, 0, 0, 16'h0400, 3'b001, 2);

    // Backpressure: result must hold while out_ready stays low
    rdy_mode = 1;
    issue(1, 5'd20, 15'h2ABC, 0, 0);
    nw = 0;
    while (!out_valid && nw < 50) begin
      @(negedge clk);
      nw++;
    end
    chk("hold_valid_seen", {31'h0, out_valid}, 32'h1);
    held = result;
    repeat (5) begin
      @(negedge clk);
      chk("hold_result", {16'h0, result}, {16'h0, held});
      chk("hold_valid", {31'h0, out_valid}, 32'h1);
      chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
    end
    rdy_mode = 0;
    wait_done();

    // Reset in the middle of a long normalization
    issue(0, 5'd15, 15'h0008, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", {31'h0, in_ready}, 32'h1);
    chk("midrst_valid_after", {31'h0, out_valid}, 32'h0);
    directed("after_rst", 0, 5'd15, 15'h4000, 0, 0, 16'h4000, 3'b000, 2);

    rdy_mode = 2;
    for (int it = 0; it < 400; it++) begin
      r  = $urandom_range(0, 19);
      re = 5'($urandom_range(1, 30));
      if (r == 3) re = 5'd30;
      if (r == 4 || r == 5) re = 5'd1;
      p  = $urandom_range(0, 14);
      rm = 15'((32'h1 << p) | ($urandom & ((32'h1 << p) - 1)));
      if (r == 2) rm = 15'h0;
      issue(1'($urandom_range(0, 1)), re, rm, (r == 0), (r == 0 || r == 1) ? 1'($urandom_range(0, 1)) | (r == 1) : 1'b0);
    end
    wait_done();
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
